// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter
//   Initiator-side endpoint of the bmem burst interface. Arbitrates 256-bit
//   line requests from the I-cache and D-cache (round-robin when both are
//   pending) and turns each one into a single 4 x 64-bit bmem burst.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   iline_*             I-cache line port (read only)
//   dline_*             D-cache line port (read or writeback)
//   bmem_*              burst memory command/data port (burst_memory responds)
//   dbg_state           current FSM state, for observation only
//
// Handshake: a cache raises *_read / *_write and holds it (address and write
// data stable) until *_resp pulses high for exactly one cycle. On bmem, a read
// is a one-cycle bmem_read command followed by BEATS cycles with bmem_resp=1
// (gaps allowed); a write is BEATS consecutive cycles of bmem_write carrying
// the beats, then the responder pulses bmem_resp once to accept the burst.
module bmem_line_adapter #(
  parameter int ADDR_W = 32,
  parameter int BEAT_W = 64,
  parameter int BEATS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_W-1:0]        iline_addr,
  input  logic                     iline_read,
  output logic [BEAT_W*BEATS-1:0]  iline_rdata,
  output logic                     iline_resp,
  input  logic [ADDR_W-1:0]        dline_addr,
  input  logic                     dline_read,
  input  logic                     dline_write,
  input  logic [BEAT_W*BEATS-1:0]  dline_wdata,
  output logic [BEAT_W*BEATS-1:0]  dline_rdata,
  output logic                     dline_resp,
  output logic [ADDR_W-1:0]        bmem_address,
  output logic                     bmem_read,
  output logic                     bmem_write,
  output logic [BEAT_W-1:0]        bmem_wdata,
  input  logic [BEAT_W-1:0]        bmem_rdata,
  input  logic                     bmem_resp,
  output logic [2:0]               dbg_state
);

  localparam int LINE_W = BEAT_W * BEATS;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_CMD  = 3'd1;
  localparam logic [2:0] RD_DATA = 3'd2;
  localparam logic [2:0] WR_DATA = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              grant_d;   // 1: current transaction belongs to D-cache
  logic              last_d;    // 1: last completed grant was D-cache
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] line_q;    // write data being sent, or read line being assembled
  logic [LINE_W-1:0] irdata_q;
  logic [LINE_W-1:0] drdata_q;

  logic              cand_d;
  logic              cand_i;
  logic              pick_d;
  logic [ADDR_W-1:0] pick_addr;
  logic              unused_offset;

  assign cand_d = dline_read | dline_write;
  assign cand_i = iline_read;
  // With both pending, the side that did not win last time gets the grant.
  assign pick_d = cand_d & (~cand_i | ~last_d);
  assign pick_addr = pick_d ? dline_addr : iline_addr;
  assign unused_offset = ^pick_addr[OFF_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      grant_d  <= 1'b0;
      last_d   <= 1'b0;
      addr_q   <= '0;
      line_q   <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cand_d | cand_i) begin
            grant_d <= pick_d;
            addr_q  <= {pick_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            cnt     <= '0;
            // A D request with both read and write high is served as a write.
            if (pick_d && dline_write) begin
              line_q <= dline_wdata;
              state  <= WR_DATA;
            end else begin
              state  <= RD_CMD;
            end
          end
        end
        RD_CMD: state <= RD_DATA;
        RD_DATA: begin
          if (bmem_resp) begin
            line_q[cnt*BEAT_W +: BEAT_W] <= bmem_rdata;
            cnt <= cnt + 1'b1;
            if (cnt == LAST_BEAT) begin
              // Publish the finished line directly so it is valid during DONE.
              if (grant_d) drdata_q <= {bmem_rdata, line_q[LINE_W-BEAT_W-1:0]};
              else         irdata_q <= {bmem_rdata, line_q[LINE_W-BEAT_W-1:0]};
              state <= DONE;
            end
          end
        end
        WR_DATA: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_BEAT) state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (bmem_resp) state <= DONE;
        end
        DONE: begin
          last_d <= grant_d;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bmem_address = addr_q;
  assign bmem_read    = (state == RD_CMD);
  assign bmem_write   = (state == WR_DATA);
  assign bmem_wdata   = bmem_write ? line_q[cnt*BEAT_W +: BEAT_W] : '0;
  assign iline_resp   = (state == DONE) & ~grant_d;
  assign dline_resp   = (state == DONE) &  grant_d;
  assign iline_rdata  = irdata_q;
  assign dline_rdata  = drdata_q;
  assign dbg_state    = state;

endmodule

// File: tb/tb_bmem_line_adapter.sv
// tb_bmem_line_adapter
//   Directed bench for bmem_line_adapter. Each task drives one scenario and
//   compares outputs against hand-computed values one cycle-step at a time.
//   Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_bmem_line_adapter;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_CMD  = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_DATA = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic         clk;
  logic         rst;
  logic [31:0]  iline_addr;
  logic         iline_read;
  logic [255:0] iline_rdata;
  logic         iline_resp;
  logic [31:0]  dline_addr;
  logic         dline_read;
  logic         dline_write;
  logic [255:0] dline_wdata;
  logic [255:0] dline_rdata;
  logic         dline_resp;
  logic [31:0]  bmem_address;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic [63:0]  bmem_rdata;
  logic         bmem_resp;
  logic [2:0]   dbg_state;

  int errors;
  int checks;

  bmem_line_adapter dut (
    .clk          (clk),
    .rst          (rst),
    .iline_addr   (iline_addr),
    .iline_read   (iline_read),
    .iline_rdata  (iline_rdata),
    .iline_resp   (iline_resp),
    .dline_addr   (dline_addr),
    .dline_read   (dline_read),
    .dline_write  (dline_write),
    .dline_wdata  (dline_wdata),
    .dline_rdata  (dline_rdata),
    .dline_resp   (dline_resp),
    .bmem_address (bmem_address),
    .bmem_read    (bmem_read),
    .bmem_write   (bmem_write),
    .bmem_wdata   (bmem_wdata),
    .bmem_rdata   (bmem_rdata),
    .bmem_resp    (bmem_resp),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic init_inputs();
    iline_addr  = '0;
    iline_read  = 1'b0;
    dline_addr  = '0;
    dline_read  = 1'b0;
    dline_write = 1'b0;
    dline_wdata = '0;
    bmem_rdata  = '0;
    bmem_resp   = 1'b0;
  endtask

  // Responder: must be called while the DUT is in RD_DATA. pat[i] is bmem_resp
  // for cycle i; a 1 carries the next beat of line.
  task automatic run_beats(input logic [255:0] line, input int n, input logic [7:0] pat);
    int idx;
    idx = 0;
    for (int i = 0; i < n; i++) begin
      bmem_resp  = pat[i];
      bmem_rdata = pat[i] ? line[idx*64 +: 64] : 64'hbad0_bad0_bad0_bad0;
      if (pat[i]) idx++;
      tick();
    end
    bmem_resp  = 1'b0;
    bmem_rdata = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    init_inputs();
    tick();
    tick();
    checks++;
    if (dbg_state !== S_IDLE) begin
      errors++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE);
    end
    checks++;
    if ({bmem_read, bmem_write, iline_resp, dline_resp} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000", {bmem_read, bmem_write, iline_resp, dline_resp});
    end
    checks++;
    if (bmem_address !== 32'h0 || bmem_wdata !== 64'h0) begin
      errors++; $display("FAIL reset_bus: addr %h wdata %h want 0", bmem_address, bmem_wdata);
    end
    checks++;
    if (iline_rdata !== 256'h0 || dline_rdata !== 256'h0) begin
      errors++; $display("FAIL reset_rdata: i %h d %h want 0", iline_rdata, dline_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_i_read();
    logic [255:0] line;
    line = {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
            64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000};
    iline_addr = 32'h0000_1004;
    iline_read = 1'b1;
    tick();  // request sampled -> RD_CMD
    checks++;
    if (bmem_read !== 1'b1 || bmem_write !== 1'b0 || bmem_address !== 32'h0000_1000) begin
      errors++; $display("FAIL iread_cmd: read %b write %b addr %h want 1 0 00001000", bmem_read, bmem_write, bmem_address);
    end
    tick();  // RD_DATA
    checks++;
    if (bmem_read !== 1'b0 || dbg_state !== S_RD_DATA) begin
      errors++; $display("FAIL iread_cmd_one_cycle: read %b state %0d want 0 %0d", bmem_read, dbg_state, S_RD_DATA);
    end
    run_beats(line, 4, 8'b0000_1111);  // now at t+6
    checks++;
    if (iline_resp !== 1'b1 || dline_resp !== 1'b0) begin
      errors++; $display("FAIL iread_resp: i %b d %b want 1 0", iline_resp, dline_resp);
    end
    checks++;
    if (iline_rdata !== line) begin
      errors++; $display("FAIL iread_data: got %h want %h", iline_rdata, line);
    end
    iline_read = 1'b0;
    tick();
    checks++;
    if (iline_resp !== 1'b0 || dbg_state !== S_IDLE || iline_rdata !== line) begin
      errors++; $display("FAIL iread_after: resp %b state %0d data %h want 0 %0d %h", iline_resp, dbg_state, iline_rdata, S_IDLE, line);
    end
  endtask

  task automatic test_d_write();
    logic [255:0] wline;
    wline = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
             64'h1111_1111_1111_1111, 64'h0F0F_0000_0000_0000};
    dline_addr  = 32'h0000_0080;
    dline_wdata = wline;
    dline_write = 1'b1;
    tick();  // WR_DATA beat 0
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bmem_write !== 1'b1 || bmem_read !== 1'b0 || bmem_wdata !== wline[k*64 +: 64] || bmem_address !== 32'h80) begin
        errors++; $display("FAIL dwrite_beat%0d: write %b read %b data %h addr %h want 1 0 %h 00000080",
                           k, bmem_write, bmem_read, bmem_wdata, bmem_address, wline[k*64 +: 64]);
      end
      tick();
    end
    checks++;
    if (bmem_write !== 1'b0 || dline_resp !== 1'b0 || dbg_state !== S_WR_WAIT) begin
      errors++; $display("FAIL dwrite_wait: write %b resp %b state %0d want 0 0 %0d", bmem_write, dline_resp, dbg_state, S_WR_WAIT);
    end
    tick();
    bmem_resp = 1'b1;  // two cycles after beat 3
    checks++;
    if (dline_resp !== 1'b0) begin
      errors++; $display("FAIL dwrite_early_resp: got %b want 0", dline_resp);
    end
    tick();
    bmem_resp = 1'b0;
    checks++;
    if (dline_resp !== 1'b1 || iline_resp !== 1'b0) begin
      errors++; $display("FAIL dwrite_resp: d %b i %b want 1 0", dline_resp, iline_resp);
    end
    dline_write = 1'b0;
    tick();
    checks++;
    if (dline_resp !== 1'b0 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL dwrite_after: resp %b state %0d want 0 %0d", dline_resp, dbg_state, S_IDLE);
    end
  endtask

  task automatic test_round_robin();
    logic [255:0] dl;
    logic [255:0] il;
    dl = {64'hD3, 64'hD2, 64'hD1, 64'hD0};
    il = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    iline_addr = 32'h0000_2000;
    dline_addr = 32'h0000_3040;
    iline_read = 1'b1;
    dline_read = 1'b1;
    tick();
    checks++;
    if (bmem_address !== 32'h0000_3040 || bmem_read !== 1'b1) begin
      errors++; $display("FAIL rr_first_d: addr %h read %b want 00003040 1", bmem_address, bmem_read);
    end
    tick();
    run_beats(dl, 4, 8'b0000_1111);
    checks++;
    if (dline_resp !== 1'b1 || iline_resp !== 1'b0 || dline_rdata !== dl) begin
      errors++; $display("FAIL rr_first_done: d %b i %b data %h want 1 0 %h", dline_resp, iline_resp, dline_rdata, dl);
    end
    tick();  // IDLE
    tick();
    checks++;
    if (bmem_address !== 32'h0000_2000 || bmem_read !== 1'b1) begin
      errors++; $display("FAIL rr_second_i: addr %h read %b want 00002000 1", bmem_address, bmem_read);
    end
    tick();
    run_beats(il, 4, 8'b0000_1111);
    checks++;
    if (iline_resp !== 1'b1 || dline_resp !== 1'b0 || iline_rdata !== il) begin
      errors++; $display("FAIL rr_second_done: i %b d %b data %h want 1 0 %h", iline_resp, dline_resp, iline_rdata, il);
    end
    tick();
    tick();
    checks++;
    if (bmem_address !== 32'h0000_3040) begin
      errors++; $display("FAIL rr_third_d: addr %h want 00003040", bmem_address);
    end
    tick();
    run_beats(dl, 4, 8'b0000_1111);
    checks++;
    if (dline_resp !== 1'b1 || iline_resp !== 1'b0) begin
      errors++; $display("FAIL rr_third_done: d %b i %b want 1 0", dline_resp, iline_resp);
    end
    iline_read = 1'b0;
    dline_read = 1'b0;
    tick();
  endtask

  task automatic test_read_gaps();
    logic [255:0] line;
    logic [7:0]   pat;
    int           pulses;
    int           idx;
    line = {64'h4444_0003, 64'h4444_0002, 64'h4444_0001, 64'h4444_0000};
    pat  = 8'b0110_0101;  // resp sequence 1,0,1,0,0,1,1
    pulses = 0;
    idx = 0;
    iline_addr = 32'h0000_4010;
    iline_read = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 7; i++) begin
      if (iline_resp | dline_resp) pulses++;
      bmem_resp  = pat[i];
      bmem_rdata = pat[i] ? line[idx*64 +: 64] : 64'hFFFF_FFFF_FFFF_FFFF;
      if (pat[i]) idx++;
      tick();
    end
    bmem_resp  = 1'b0;
    bmem_rdata = '0;
    checks++;
    if (iline_resp !== 1'b1 || iline_rdata !== line) begin
      errors++; $display("FAIL gaps_done: resp %b data %h want 1 %h", iline_resp, iline_rdata, line);
    end
    if (iline_resp | dline_resp) pulses++;
    iline_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (iline_resp | dline_resp) pulses++;
    end
    checks++;
    if (pulses != 1) begin
      errors++; $display("FAIL gaps_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [255:0] l1;
    logic [255:0] l2;
    l1 = {64'h5100_0003, 64'h5100_0002, 64'h5100_0001, 64'h5100_0000};
    l2 = {64'h5200_0003, 64'h5200_0002, 64'h5200_0001, 64'h5200_0000};
    iline_addr = 32'h0000_5020;
    iline_read = 1'b1;
    tick();
    tick();
    run_beats(l1, 2, 8'b0000_0011);
    checks++;
    if (dbg_state !== S_RD_DATA) begin
      errors++; $display("FAIL mid_state: got %0d want %0d", dbg_state, S_RD_DATA);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (dbg_state !== S_IDLE || {bmem_read, bmem_write, iline_resp, dline_resp} !== 4'b0000) begin
      errors++; $display("FAIL mid_reset_ctrl: state %0d ctrl %b want %0d 0000", dbg_state,
                         {bmem_read, bmem_write, iline_resp, dline_resp}, S_IDLE);
    end
    checks++;
    if (bmem_address !== 32'h0 || iline_rdata !== 256'h0 || dline_rdata !== 256'h0) begin
      errors++; $display("FAIL mid_reset_regs: addr %h i %h d %h want 0", bmem_address, iline_rdata, dline_rdata);
    end
    tick();  // request still held -> RD_CMD
    checks++;
    if (bmem_read !== 1'b1 || bmem_address !== 32'h0000_5020) begin
      errors++; $display("FAIL mid_restart_cmd: read %b addr %h want 1 00005020", bmem_read, bmem_address);
    end
    tick();
    run_beats(l2, 4, 8'b0000_1111);
    checks++;
    if (iline_resp !== 1'b1 || iline_rdata !== l2) begin
      errors++; $display("FAIL mid_restart_done: resp %b data %h want 1 %h", iline_resp, iline_rdata, l2);
    end
    iline_read = 1'b0;
    tick();
  endtask

  task automatic test_spurious_resp();
    logic [255:0] wline;
    wline = {64'hC3, 64'hC2, 64'hC1, 64'hC0};
    bmem_resp = 1'b1;
    tick();
    tick();
    checks++;
    if (dbg_state !== S_IDLE || iline_resp !== 1'b0 || dline_resp !== 1'b0) begin
      errors++; $display("FAIL spur_idle: state %0d i %b d %b want %0d 0 0", dbg_state, iline_resp, dline_resp, S_IDLE);
    end
    dline_addr  = 32'h0000_01E8;
    dline_wdata = wline;
    dline_write = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bmem_write !== 1'b1 || bmem_wdata !== wline[k*64 +: 64] || bmem_address !== 32'h0000_01E0) begin
        errors++; $display("FAIL spur_wbeat%0d: write %b data %h addr %h want 1 %h 000001e0",
                           k, bmem_write, bmem_wdata, bmem_address, wline[k*64 +: 64]);
      end
      tick();
    end
    bmem_resp = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dbg_state !== S_WR_WAIT || dline_resp !== 1'b0) begin
        errors++; $display("FAIL spur_wait%0d: state %0d resp %b want %0d 0", i, dbg_state, dline_resp, S_WR_WAIT);
      end
      tick();
    end
    bmem_resp = 1'b1;
    tick();
    bmem_resp = 1'b0;
    checks++;
    if (dline_resp !== 1'b1 || iline_resp !== 1'b0) begin
      errors++; $display("FAIL spur_done: d %b i %b want 1 0", dline_resp, iline_resp);
    end
    dline_write = 1'b0;
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    init_inputs();
    test_reset();
    test_i_read();
    test_d_write();
    test_round_robin();
    test_read_gaps();
    test_reset_mid_burst();
    test_spurious_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
